accumulator_buffer: RTL and testbench
=====================================

Name: accumulator_buffer

Overview:
Banked output-partial-sum buffer sitting directly upstream of the ppu.
- Write side: the multiplier/crossbar array issues one accumulate per bank per cycle; each product is added into the addressed entry with signed saturation.
- Read side: the ppu reads one entry per cycle from any bank.
- A sweep clears all entries between channel groups.

Parameters:
BANK_COUNT, 32, number of independent banks
TILE_SIZE, 256, entries per bank
DATA_WIDTH, 8, signed width of products and stored sums

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous active-low reset
buffer_entry_write  input  [BANK_COUNT] x clog2(TILE_SIZE)  per-bank write entry
buffer_data_write  input  [BANK_COUNT] x DATA_WIDTH  per-bank signed product
buffer_write_enable  input  [BANK_COUNT] x 1  per-bank accumulate request
buffer_bank_read  input  clog2(BANK_COUNT)  read bank select
buffer_bank_entry  input  clog2(TILE_SIZE)  read entry select
buffer_read_enable  input  1  read request
buffer_data_read  output  DATA_WIDTH  read data
buffer_read_valid  output  1  buffer_data_read valid this cycle
clear_start  input  1  request full clear (channel_group_done from control)
clear_busy  output  1  clear sweep in progress
overflow_flag  output  1  sticky: a saturation occurred

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=CLEAR, sweep counter=0.
  - clear_busy=1, buffer_read_valid=0, buffer_data_read=0, overflow_flag=0.
  - Pipeline valids are cleared.
- States:
  - CLEAR: at each cycle, entry[counter] is written to 0 in every bank, then counter increments. After entry TILE_SIZE-1 is written, the next state is IDLE and clear_busy=0 in that next cycle. A sweep takes exactly TILE_SIZE cycles.
  - IDLE: accumulate and read are accepted. clear_start=1 -> CLEAR next cycle, counter=0, overflow_flag cleared.
- While in CLEAR:
  - Writes, reads and clear_start are ignored; a sweep is never restarted.
  - buffer_read_valid=0.
- Accumulate pipeline, per bank, independent across banks:
  - Stage 1 (cycle t): capture enable, entry and data; read the stored value.
  - Stage 2 (cycle t+1): write sum = sat(old + data) to that entry.
  - Forwarding: if stage 2 writes entry e in the same cycle stage 1 reads e, stage 1 uses the stage-2 sum. Back-to-back writes to one entry therefore accumulate exactly.
  - Throughput: 1 per bank per cycle.
- Saturation:
  - Exact signed add at DATA_WIDTH+1 bits.
  - Results are clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Any clamp sets overflow_flag (sticky until reset or an accepted clear_start).
- clear_start accepted at cycle t: the stage-2 update at t+1 is dropped (the clear wins). Stage-1 captures at t are discarded. After the sweep, every entry reads 0.
- Read:
  - Accepted at t (IDLE only) -> buffer_read_valid=1 and data at t+1.
  - Data includes every accumulate accepted at t-1 or earlier (forward from stage 2 if needed). It excludes an accumulate accepted at t.
  - When buffer_read_valid=0, buffer_data_read=0.
- Reset mid-sweep or mid-accumulate: same as the reset values above; a fresh full sweep follows.
- Entry indices are always in range by width; there is no wrap-around handling.

Decomposition:
- Package accumulator_buffer_pkg holds:
  - the DATA_WIDTH default constant;
  - the state enum {CLEAR, IDLE};
  - a function sat_add(a, b, output overflow).
- One sub-module, accumulator_bank: single bank, 2-stage RMW with forwarding, clear-write port, combinational read port. It is instantiated BANK_COUNT times.
- The top level holds the FSM, sweep counter, read mux/register and overflow OR.

Test Plan:
- Reset, then hold reset_n=1 -> clear_busy=1 for exactly 256 cycles. After that, a read of bank 5, entry 17 returns 0 with valid one cycle later.
- Bank 3, entry 9: write 10, 20, 30 on consecutive cycles -> read issued 2 cycles after the last write returns 60. Overflow_flag stays 0.
- Bank 0, entry 1: write 100 then 100 -> read returns 127 and overflow_flag=1. Writes of -100, -100 to entry 2 read back -128.
- All 32 banks write entry 255 with value=bank index in the same cycle -> reading each bank returns its index. Banks do not interact.
- Write 7 to bank 4, entry 0 at t; clear_start at t -> clear_busy=1 from t+1 for 256 cycles. The read after the sweep returns 0 and overflow_flag=0.
- Write 5 to bank 2, entry 3 at t; read the same entry at t+1 -> returns 5 at t+2. A read at t of the same entry returns the pre-write value.

Source files
------------

// File: rtl/accumulator_buffer_pkg.sv
// Shared types and helpers for the banked partial-sum buffer.
// Holds the default data width, FSM states and the saturating adder.
package accumulator_buffer_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Add two sign-extended operands and clamp the result to a w-bit signed range.
    function automatic logic signed [31:0] sat_add(
        input  logic signed [31:0] a,
        input  logic signed [31:0] b,
        input  int                 w,
        output logic               overflow
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s        = a + b;
        hi       = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo       = -hi - 32'sd1;
        overflow = 1'b0;
        if (s > hi) begin
            s        = hi;
            overflow = 1'b1;
        end else if (s < lo) begin
            s        = lo;
            overflow = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/accumulator_bank.sv
// One bank of the partial-sum buffer: two-stage read-modify-write
// with stage-2 forwarding, a clear-write port and a combinational read port.
module accumulator_bank
    import accumulator_buffer_pkg::*;
#(
    parameter  int TILE_SIZE  = 256,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int EW         = $clog2(TILE_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [EW-1:0]         wr_entry,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_en,
    input  logic [EW-1:0]         clr_entry,
    input  logic [EW-1:0]         rd_entry,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ovf
);

    logic signed [DATA_WIDTH-1:0] mem [TILE_SIZE];

    logic                         s2_valid;
    logic [EW-1:0]                s2_entry;
    logic signed [DATA_WIDTH-1:0] s2_data;
    logic signed [DATA_WIDTH-1:0] s2_old;

    logic signed [31:0]           sum_w;
    logic signed [DATA_WIDTH-1:0] sum;
    logic                         clamp;
    logic signed [DATA_WIDTH-1:0] old_val;
    logic                         unused_hi;

    always_comb begin
        clamp = 1'b0;
        sum_w = sat_add(32'(s2_old), 32'(s2_data), DATA_WIDTH, clamp);
    end

    assign sum       = sum_w[DATA_WIDTH-1:0];
    assign unused_hi = ^sum_w[31:DATA_WIDTH];
    assign ovf       = s2_valid & clamp;

    // Stage 1 sees the in-flight stage-2 sum so back-to-back hits accumulate.
    assign old_val = (s2_valid && s2_entry == wr_entry) ? sum : mem[wr_entry];
    assign rd_data = (s2_valid && s2_entry == rd_entry) ? sum : mem[rd_entry];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= wr_en;
            if (wr_en) begin
                s2_entry <= wr_entry;
                s2_data  <= wr_data;
                s2_old   <= old_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_entry] <= '0;
        end else if (s2_valid && reset_n) begin
            mem[s2_entry] <= sum;
        end
    end

endmodule

// File: rtl/accumulator_buffer.sv
// Banked output-partial-sum buffer feeding the ppu.
// Owns the clear sweep FSM, the registered read mux and the sticky overflow.
module accumulator_buffer
    import accumulator_buffer_pkg::*;
#(
    parameter  int BANK_COUNT = 32,
    parameter  int TILE_SIZE  = 256,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int EW         = $clog2(TILE_SIZE),
    localparam int BW         = $clog2(BANK_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [BANK_COUNT-1:0][EW-1:0]        buffer_entry_write,
    input  logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] buffer_data_write,
    input  logic [BANK_COUNT-1:0]                buffer_write_enable,
    input  logic [BW-1:0]                        buffer_bank_read,
    input  logic [EW-1:0]                        buffer_bank_entry,
    input  logic                                 buffer_read_enable,
    output logic [DATA_WIDTH-1:0]                buffer_data_read,
    output logic                                 buffer_read_valid,
    input  logic                                 clear_start,
    output logic                                 clear_busy,
    output logic                                 overflow_flag
);

    state_t        state;
    state_t        state_n;
    logic [EW-1:0] cnt;
    logic [EW-1:0] cnt_n;

    logic idle;
    logic sweeping;
    logic clr_acc;
    logic rd_acc;

    logic [BANK_COUNT-1:0]                 bank_we;
    logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] bank_rd;
    logic [BANK_COUNT-1:0]                 bank_ovf;

    assign idle       = (state == IDLE);
    assign sweeping   = (state == CLEAR);
    assign clr_acc    = idle & clear_start;
    assign rd_acc     = idle & buffer_read_enable;
    assign clear_busy = sweeping;

    // A clear accepted this cycle discards the stage-1 captures of the same cycle.
    assign bank_we = buffer_write_enable & {BANK_COUNT{idle & ~clear_start}};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            CLEAR: begin
                if (cnt == EW'(TILE_SIZE - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clear_start) begin
                    cnt_n   = '0;
                    state_n = CLEAR;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        accumulator_bank #(
            .TILE_SIZE  (TILE_SIZE),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en     (bank_we[b]),
            .wr_entry  (buffer_entry_write[b]),
            .wr_data   (buffer_data_write[b]),
            .clr_en    (sweeping),
            .clr_entry (cnt),
            .rd_entry  (buffer_bank_entry),
            .rd_data   (bank_rd[b]),
            .ovf       (bank_ovf[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buffer_read_valid <= 1'b0;
            buffer_data_read  <= '0;
        end else begin
            buffer_read_valid <= rd_acc;
            buffer_data_read  <= rd_acc ? bank_rd[buffer_bank_read] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_flag <= 1'b0;
        end else if (clr_acc) begin
            overflow_flag <= 1'b0;
        end else if (|bank_ovf) begin
            overflow_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accumulator_buffer.sv
// Self-checking bench for accumulator_buffer: vector table, corner
// sequences and a randomized phase against an array-based reference.
module tb_accumulator_buffer;

    localparam int NB = 32;
    localparam int TS = 256;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NB-1:0][7:0]  ent_w;
    logic [NB-1:0][7:0]  dat_w;
    logic [NB-1:0]       wen;
    logic [4:0]          rbank;
    logic [7:0]          rent;
    logic                ren;
    logic                clear_start;
    logic [7:0]          rdata;
    logic                rvalid;
    logic                clear_busy;
    logic                ovf;

    int n_vec = 0;
    int n_err = 0;
    int ref_mem [NB][TS];
    bit ref_ovf;

    typedef struct {
        bit wr;
        int wb;
        int wentry;
        int wd;
        bit rd;
        int rb;
        int rentry;
        bit ev;
        int ed;
        bit eo;
    } row_t;

    row_t rows [14];

    always #5 clk = ~clk;

    accumulator_buffer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .buffer_entry_write  (ent_w),
        .buffer_data_write   (dat_w),
        .buffer_write_enable (wen),
        .buffer_bank_read    (rbank),
        .buffer_bank_entry   (rent),
        .buffer_read_enable  (ren),
        .buffer_data_read    (rdata),
        .buffer_read_valid   (rvalid),
        .clear_start         (clear_start),
        .clear_busy          (clear_busy),
        .overflow_flag       (ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        wen         = '0;
        ent_w       = '0;
        dat_w       = '0;
        ren         = 1'b0;
        rbank       = '0;
        rent        = '0;
        clear_start = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic row_t mk(bit wr, int wb, int we_, int wd, bit rd,
                                int rb, int re_, bit ev, int ed, bit eo);
        row_t r;
        r.wr = wr; r.wb = wb; r.wentry = we_; r.wd = wd;
        r.rd = rd; r.rb = rb; r.rentry = re_;
        r.ev = ev; r.ed = ed; r.eo = eo;
        return r;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int sdata;
        return int'($signed(rdata));
    endfunction

    initial begin
        int n;
        int exp_rd;
        bit do_rd;
        int v;

        rows[0]  = mk(0, 0, 0, 0,    1, 5, 17, 1, 0,    0);
        rows[1]  = mk(1, 3, 9, 10,   0, 0, 0,  0, 0,    0);
        rows[2]  = mk(1, 3, 9, 20,   0, 0, 0,  0, 0,    0);
        rows[3]  = mk(1, 3, 9, 30,   0, 0, 0,  0, 0,    0);
        rows[4]  = mk(0, 0, 0, 0,    0, 0, 0,  0, 0,    0);
        rows[5]  = mk(0, 0, 0, 0,    1, 3, 9,  1, 60,   0);
        rows[6]  = mk(1, 2, 3, 5,    1, 2, 3,  1, 0,    0);
        rows[7]  = mk(0, 0, 0, 0,    1, 2, 3,  1, 5,    0);
        rows[8]  = mk(1, 0, 1, 100,  0, 0, 0,  0, 0,    0);
        rows[9]  = mk(1, 0, 1, 100,  0, 0, 0,  0, 0,    0);
        rows[10] = mk(1, 0, 2, -100, 1, 0, 1,  1, 127,  1);
        rows[11] = mk(1, 0, 2, -100, 0, 0, 0,  0, 0,    1);
        rows[12] = mk(0, 0, 0, 0,    0, 0, 0,  0, 0,    1);
        rows[13] = mk(0, 0, 0, 0,    1, 0, 2,  1, -128, 1);

        idle_in();
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_clear_busy", clear_busy, 1);
        chk("rst_valid", rvalid, 0);
        chk("rst_data", rdata, 0);
        chk("rst_overflow", ovf, 0);

        reset_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (clear_busy && n < 1000);
        chk("sweep_len_after_reset", n, TS);

        for (int i = 0; i < 14; i++) begin
            idle_in();
            if (rows[i].wr) begin
                wen[rows[i].wb]   = 1'b1;
                ent_w[rows[i].wb] = 8'(rows[i].wentry);
                dat_w[rows[i].wb] = 8'(rows[i].wd);
            end
            ren   = rows[i].rd;
            rbank = 5'(rows[i].rb);
            rent  = 8'(rows[i].rentry);
            tick();
            chk($sformatf("row%0d_valid", i), rvalid, rows[i].ev);
            chk($sformatf("row%0d_data", i), sdata(), rows[i].ed);
            chk($sformatf("row%0d_ovf", i), ovf, rows[i].eo);
        end

        idle_in();
        for (int b = 0; b < NB; b++) begin
            wen[b]   = 1'b1;
            ent_w[b] = 8'd255;
            dat_w[b] = 8'(b);
        end
        tick();
        idle_in();
        tick();
        for (int b = 0; b < NB; b++) begin
            ren   = 1'b1;
            rbank = 5'(b);
            rent  = 8'd255;
            tick();
            chk($sformatf("bank%0d_e255", b), sdata(), b);
        end

        idle_in();
        wen[4]      = 1'b1;
        ent_w[4]    = 8'd0;
        dat_w[4]    = 8'd7;
        clear_start = 1'b1;
        tick();
        idle_in();
        chk("clear_busy_t1", clear_busy, 1);
        n = 0;
        while (clear_busy && n < 1000) begin
            if (n == 10) begin
                clear_start = 1'b1;
                wen[4]      = 1'b1;
                ent_w[4]    = 8'd0;
                dat_w[4]    = 8'd9;
                ren         = 1'b1;
                rbank       = 5'd4;
            end
            tick();
            n++;
            if (n == 11) chk("read_in_clear_valid", rvalid, 0);
            idle_in();
        end
        chk("sweep_len_after_clear", n, TS);
        chk("ovf_after_clear", ovf, 0);
        ren   = 1'b1;
        rbank = 5'd4;
        rent  = 8'd0;
        tick();
        chk("b4_e0_after_clear_valid", rvalid, 1);
        chk("b4_e0_after_clear", sdata(), 0);
        rbank = 5'd0;
        rent  = 8'd1;
        tick();
        chk("b0_e1_after_clear", sdata(), 0);
        idle_in();
        tick();

        for (int b = 0; b < NB; b++)
            for (int e = 0; e < TS; e++)
                ref_mem[b][e] = 0;
        ref_ovf = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            idle_in();
            do_rd = ($urandom_range(0, 1) == 1);
            ren   = do_rd;
            rbank = 5'($urandom_range(0, NB - 1));
            rent  = 8'($urandom_range(0, 3));
            exp_rd = ref_mem[rbank][rent];
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wen[b]   = 1'b1;
                    ent_w[b] = 8'($urandom_range(0, 3));
                    dat_w[b] = 8'($urandom);
                    v = ref_mem[b][ent_w[b]] + int'($signed(dat_w[b]));
                    if (sat8(v) != v) ref_ovf = 1'b1;
                    ref_mem[b][ent_w[b]] = sat8(v);
                end
            end
            tick();
            chk($sformatf("rnd%0d_valid", c), rvalid, do_rd);
            if (do_rd) chk($sformatf("rnd%0d_data", c), sdata(), exp_rd);
        end
        idle_in();
        tick();
        tick();
        chk("rnd_overflow", ovf, ref_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
